// File: rtl/fir_lite_master.sv
// AXI-Lite initiator for the fir config port. It writes the length and the taps, reads the taps back, starts the engine, then polls for ap_done.
// Each transaction is followed by one idle cycle. Every valid waits on its own ready, and rready waits on rvalid.
module fir_lite_master #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int POLL_MAX    = 65535
) (
   input  logic                     axis_clk,
   input  logic                     axis_rst,
   input  logic                     start,
   input  logic [31:0]              data_length,
   input  logic [Tape_Num*32-1:0]   coef_flat,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               err_code,
   output logic [3:0]               err_idx,
   output logic                     awvalid,
   output logic [pADDR_WIDTH-1:0]   awaddr,
   input  logic                     awready,
   output logic                     wvalid,
   output logic [pDATA_WIDTH-1:0]   wdata,
   input  logic                     wready,
   output logic                     arvalid,
   output logic [pADDR_WIDTH-1:0]   araddr,
   input  logic                     arready,
   input  logic                     rvalid,
   input  logic [pDATA_WIDTH-1:0]   rdata,
   output logic                     rready
);

   localparam int KW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
   localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(Tape_Num - 1);
   localparam logic [PW-1:0] P_LAST = PW'(POLL_MAX - 1);
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h34);
   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h30);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_LEN, S_WR_TAP, S_RD_TAP, S_WR_START, S_POLL, S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_arvalid;
   logic                    r_rready;
   logic                    r_wr_act;
   logic                    r_gap;
   logic [pADDR_WIDTH-1:0]  r_awaddr;
   logic [pADDR_WIDTH-1:0]  r_araddr;
   logic [pDATA_WIDTH-1:0]  r_wdata;
   logic [Tape_Num*32-1:0]  r_coef;
   logic [KW-1:0]           r_k;
   logic [PW-1:0]           r_poll;
   logic [1:0]              r_err_code;
   logic [3:0]              r_err_idx;

   logic                    w_start_acc;
   logic                    w_wr_cmpl;
   logic                    w_rd_cmpl;
   logic                    w_k_last;
   logic                    w_tap_bad;
   logic                    w_launch;
   logic                    w_nxt_is_wr;
   logic                    w_nxt_is_rd;
   logic [31:0]             w_coef_k;
   logic [pADDR_WIDTH-1:0]  w_tap_addr;
   logic [pADDR_WIDTH-1:0]  w_awaddr_nxt;
   logic [pADDR_WIDTH-1:0]  w_araddr_nxt;
   logic [pDATA_WIDTH-1:0]  w_wdata_nxt;

   assign w_start_acc = (r_state == S_IDLE) && start;
   // A channel whose valid has already dropped inside an active write has completed its handshake.
   assign w_wr_cmpl   = r_wr_act && (!r_awvalid || awready) && (!r_wvalid || wready);
   assign w_rd_cmpl   = r_rready && rvalid;
   assign w_k_last    = (r_k == K_LAST);
   assign w_tap_bad   = (rdata != pDATA_WIDTH'(w_coef_k));
   assign w_launch    = w_start_acc || r_gap;
   assign w_tap_addr  = pADDR_WIDTH'({r_k, 2'b00});
   assign w_nxt_is_wr = (w_state_nxt == S_WR_LEN) || (w_state_nxt == S_WR_TAP) ||
                        (w_state_nxt == S_WR_START);
   assign w_nxt_is_rd = (w_state_nxt == S_RD_TAP) || (w_state_nxt == S_POLL);

   always_comb begin
      w_coef_k = '0;
      for (int i = 0; i < Tape_Num; i++) begin
         if (r_k == KW'(i)) w_coef_k = r_coef[32*i +: 32];
      end
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (start) w_state_nxt = S_WR_LEN;
         S_WR_LEN:   if (w_wr_cmpl) w_state_nxt = S_WR_TAP;
         S_WR_TAP:   if (w_wr_cmpl && w_k_last) w_state_nxt = S_RD_TAP;
         S_RD_TAP:   if (w_rd_cmpl && w_k_last)
                        w_state_nxt = (w_tap_bad || (r_err_code != 2'd0)) ? S_DONE : S_WR_START;
         S_WR_START: if (w_wr_cmpl) w_state_nxt = S_POLL;
         S_POLL:     if (w_rd_cmpl && (rdata[1] || (r_poll == P_LAST))) w_state_nxt = S_DONE;
         S_DONE:     w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_IDLE:  busy = 1'b0;
         S_DONE:  done = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   // Address/data for the transaction about to be launched, keyed by the state it belongs to.
   always_comb begin
      w_awaddr_nxt = '0;
      w_araddr_nxt = '0;
      w_wdata_nxt  = '0;
      case (w_state_nxt)
         S_WR_LEN: begin
            w_awaddr_nxt = ADDR_LEN;
            w_wdata_nxt  = pDATA_WIDTH'(data_length);
         end
         S_WR_TAP: begin
            w_awaddr_nxt = w_tap_addr;
            w_wdata_nxt  = pDATA_WIDTH'(w_coef_k);
         end
         S_WR_START: begin
            w_awaddr_nxt = ADDR_CTRL;
            w_wdata_nxt  = pDATA_WIDTH'(1);
         end
         S_RD_TAP: w_araddr_nxt = w_tap_addr;
         S_POLL:   w_araddr_nxt = ADDR_CTRL;
         default:  ;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_wr_act   <= 1'b0;
         r_gap      <= 1'b0;
         r_awaddr   <= '0;
         r_araddr   <= '0;
         r_wdata    <= '0;
         r_coef     <= '0;
         r_k        <= '0;
         r_poll     <= '0;
         r_err_code <= 2'd0;
         r_err_idx  <= 4'd0;
      end else begin
         r_gap <= (w_wr_cmpl || w_rd_cmpl) && (w_nxt_is_wr || w_nxt_is_rd);

         if (w_start_acc) begin
            r_coef     <= coef_flat;
            r_k        <= '0;
            r_poll     <= '0;
            r_err_code <= 2'd0;
            r_err_idx  <= 4'd0;
         end

         if (r_awvalid && awready) r_awvalid <= 1'b0;
         if (r_wvalid && wready)   r_wvalid  <= 1'b0;
         if (w_wr_cmpl)            r_wr_act  <= 1'b0;
         if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
         end
         if (w_rd_cmpl) r_rready <= 1'b0;

         if (w_launch && w_nxt_is_wr) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wr_act  <= 1'b1;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
         end
         if (w_launch && w_nxt_is_rd) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_araddr_nxt;
         end

         if (w_wr_cmpl && (r_state == S_WR_TAP))
            r_k <= w_k_last ? '0 : r_k + 1'b1;

         // Only the first mismatching tap is recorded, but every tap is still read.
         if (w_rd_cmpl && (r_state == S_RD_TAP)) begin
            r_k <= w_k_last ? '0 : r_k + 1'b1;
            if (w_tap_bad && (r_err_code == 2'd0)) begin
               r_err_code <= 2'd1;
               r_err_idx  <= 4'(r_k);
            end
         end

         if (w_rd_cmpl && (r_state == S_POLL)) begin
            r_poll <= r_poll + 1'b1;
            if (!rdata[1] && (r_poll == P_LAST)) r_err_code <= 2'd2;
         end
      end
   end

   assign awvalid  = r_awvalid;
   assign awaddr   = r_awaddr;
   assign wvalid   = r_wvalid;
   assign wdata    = r_wdata;
   assign arvalid  = r_arvalid;
   assign araddr   = r_araddr;
   assign rready   = r_rready;
   assign err_code = r_err_code;
   assign err_idx  = r_err_idx;

endmodule

// File: tb/tb_fir_lite_master.sv
// Bench for fir_lite_master: an AXI-Lite register responder with configurable ready and data delays,
// plus a queue of expected transactions and results that a monitor checks against the observed handshakes.
module tb_fir_lite_master;
   localparam int TAPS = 11;
   localparam int PMAX = 8;

   logic                 clk = 1'b0;
   logic                 axis_rst;
   logic                 start;
   logic [31:0]          data_length;
   logic [TAPS*32-1:0]   coef_flat;
   logic                 busy, done;
   logic [1:0]           err_code;
   logic [3:0]           err_idx;
   logic                 awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [11:0]          awaddr, araddr;
   logic [31:0]          wdata, rdata;

   always #5 clk = ~clk;

   fir_lite_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS), .POLL_MAX(PMAX)) dut (
      .axis_clk(clk), .axis_rst(axis_rst), .start(start), .data_length(data_length),
      .coef_flat(coef_flat), .busy(busy), .done(done), .err_code(err_code), .err_idx(err_idx),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready)
   );

   typedef struct { bit is_wr; logic [11:0] addr; logic [31:0] data; } txn_t;
   typedef struct { logic [1:0] code; logic [3:0] idx; } res_t;
   txn_t exp_q[$];
   res_t res_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_cnt = 0;

   int          aw_dly, w_dly, ar_dly, r_dly, bad_tap, done_after;
   logic [31:0] cur_coef [TAPS];
   logic [31:0] rsp_len;
   logic [31:0] rsp_taps [TAPS];
   bit          ap_started;
   int          poll_n;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic txn_t mk(input bit w, input logic [11:0] a, input logic [31:0] d);
      txn_t t;
      t.is_wr = w; t.addr = a; t.data = d;
      return t;
   endfunction

   // Reference: the transaction list and result implied by the configuration.
   task automatic build_expect(input logic [31:0] len);
      res_t r;
      int   npoll;
      exp_q.push_back(mk(1'b1, 12'h034, len));
      for (int k = 0; k < TAPS; k++) exp_q.push_back(mk(1'b1, 12'(4*k), cur_coef[k]));
      for (int k = 0; k < TAPS; k++) exp_q.push_back(mk(1'b0, 12'(4*k), 32'h0));
      if (bad_tap >= 0 && bad_tap < TAPS) begin
         r.code = 2'd1; r.idx = 4'(bad_tap);
      end else begin
         exp_q.push_back(mk(1'b1, 12'h030, 32'h1));
         npoll = (done_after >= 1 && done_after <= PMAX) ? done_after : PMAX;
         for (int i = 0; i < npoll; i++) exp_q.push_back(mk(1'b0, 12'h030, 32'h0));
         r.code = (npoll == done_after) ? 2'd0 : 2'd2;
         r.idx  = 4'd0;
      end
      res_q.push_back(r);
   endtask

   task automatic rsp_write(input logic [11:0] a, input logic [31:0] d);
      int k;
      k = int'(a[11:2]);
      if (a == 12'h034) rsp_len = d;
      else if (a == 12'h030) begin ap_started = 1'b1; poll_n = 0; end
      else if (a[1:0] == 2'b00 && k < TAPS) rsp_taps[k] = d;
   endtask

   function automatic logic [31:0] rsp_read(input logic [11:0] a);
      int k;
      k = int'(a[11:2]);
      if (a == 12'h030) begin
         poll_n++;
         return (ap_started && done_after != 0 && poll_n >= done_after) ? 32'h2 : 32'h0;
      end
      if (a == 12'h034) return rsp_len;
      if (k < TAPS) return (k == bad_tap) ? 32'hDEAD : rsp_taps[k];
      return 32'h0;
   endfunction

   // Responder: handshakes are sampled at the negedge and acted upon just after the next posedge.
   initial begin
      bit s_aw, s_w, s_ar, s_r, s_rst, pa_v, pd_v, rd_pend;
      logic [11:0] s_aa, s_ra, pa, rd_addr;
      logic [31:0] s_wd, pd;
      int aw_cnt, w_cnt, ar_cnt, r_cnt;
      pa_v = 0; pd_v = 0; rd_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      pa = '0; pd = '0; rd_addr = '0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      forever begin
         @(negedge clk);
         s_rst = axis_rst;
         s_aw = awvalid && awready; s_aa = awaddr;
         s_w  = wvalid && wready;   s_wd = wdata;
         s_ar = arvalid && arready; s_ra = araddr;
         s_r  = rvalid && rready;
         @(posedge clk); #1;
         if (s_rst) begin
            pa_v = 0; pd_v = 0; rd_pend = 0; rvalid = 1'b0;
         end else begin
            if (s_aw) begin pa_v = 1; pa = s_aa; end
            if (s_w)  begin pd_v = 1; pd = s_wd; end
            if (pa_v && pd_v) begin rsp_write(pa, pd); pa_v = 0; pd_v = 0; end
            if (s_r)  begin rvalid = 1'b0; rd_pend = 0; end
            if (s_ar) begin rd_pend = 1; rd_addr = s_ra; r_cnt = 0; end
         end
         awready = (aw_dly == 0) || (awvalid && aw_cnt >= aw_dly);
         aw_cnt  = (awvalid && !awready) ? aw_cnt + 1 : 0;
         wready  = (w_dly == 0) || (wvalid && w_cnt >= w_dly);
         w_cnt   = (wvalid && !wready) ? w_cnt + 1 : 0;
         arready = (ar_dly == 0) || (arvalid && ar_cnt >= ar_dly);
         ar_cnt  = (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (rd_pend && rready && !rvalid) begin
            if (r_cnt >= r_dly) begin rvalid = 1'b1; rdata = rsp_read(rd_addr); end
            else r_cnt++;
         end
      end
   end

   task automatic cmp_txn(input bit w, input logic [11:0] a, input logic [31:0] d);
      txn_t e;
      if (exp_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL extra_txn: got %s addr %0h, required none", w ? "write" : "read", a);
      end else begin
         e = exp_q.pop_front();
         check("txn_kind", w, e.is_wr);
         check("txn_addr", a, e.addr);
         if (e.is_wr) check("txn_wdata", d, e.data);
      end
   endtask

   // Monitor: reassembles transactions and checks protocol rules cycle by cycle.
   initial begin
      bit p_aw_hs, p_w_hs, p_ar_hs, p_r_hs, p_awv, p_wv, p_arv;
      bit have_aw, have_w, have_ar, in_gap, any_v;
      logic [11:0] p_awaddr, p_araddr, m_aw_a, m_ar_a;
      logic [31:0] p_wdata, m_w_d;
      int gap_cnt;
      res_t r;
      p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_r_hs = 0; p_awv = 0; p_wv = 0; p_arv = 0;
      have_aw = 0; have_w = 0; have_ar = 0; in_gap = 0; gap_cnt = 0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0; m_aw_a = '0; m_ar_a = '0; m_w_d = '0;
      forever begin
         @(negedge clk);
         if (axis_rst) begin
            p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_r_hs = 0; p_awv = 0; p_wv = 0; p_arv = 0;
            have_aw = 0; have_w = 0; have_ar = 0; in_gap = 0;
         end else begin
            if (p_aw_hs) check("aw_drop", awvalid, 1'b0);
            if (p_w_hs)  check("w_drop", wvalid, 1'b0);
            if (p_ar_hs) check("ar_drop", arvalid, 1'b0);
            if (p_r_hs)  check("r_drop", rready, 1'b0);
            if (p_awv && !p_aw_hs) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_w_hs)   check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
            if (p_arv && !p_ar_hs) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            any_v = awvalid || wvalid || arvalid || rready;
            if (in_gap && any_v) begin check("gap_cycles", gap_cnt, 1); in_gap = 0; end
            else if (in_gap) gap_cnt++;
            if (awvalid && awready) begin have_aw = 1; m_aw_a = awaddr; end
            if (wvalid && wready)   begin have_w = 1;  m_w_d = wdata; end
            if (have_aw && have_w) begin
               cmp_txn(1'b1, m_aw_a, m_w_d);
               have_aw = 0; have_w = 0; in_gap = 1; gap_cnt = 0;
            end
            if (arvalid && arready) begin have_ar = 1; m_ar_a = araddr; end
            if (rvalid && rready) begin
               check("r_after_ar", have_ar, 1'b1);
               cmp_txn(1'b0, m_ar_a, rdata);
               have_ar = 0; in_gap = 1; gap_cnt = 0;
            end
            if (done) begin
               done_cnt++;
               in_gap = 0;
               if (res_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_done: got done pulse, required none");
               end else begin
                  r = res_q.pop_front();
                  check("err_code", err_code, r.code);
                  check("err_idx", err_idx, r.idx);
                  check("busy_at_done", busy, 1'b0);
                  check("txn_left", exp_q.size(), 0);
               end
            end
            p_aw_hs = awvalid && awready; p_w_hs = wvalid && wready;
            p_ar_hs = arvalid && arready; p_r_hs = rvalid && rready;
            p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
            p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
         end
      end
   end

   task automatic set_dly(input int a, input int w, input int ar, input int r);
      aw_dly = a; w_dly = w; ar_dly = ar; r_dly = r;
   endtask

   task automatic set_nominal();
      int nom [TAPS];
      nom = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
      for (int k = 0; k < TAPS; k++) cur_coef[k] = nom[k];
   endtask

   task automatic set_random();
      for (int k = 0; k < TAPS; k++) cur_coef[k] = $urandom;
   endtask

   task automatic pulse_start(input logic [31:0] len);
      build_expect(len);
      ap_started = 1'b0; poll_n = 0;
      @(posedge clk); #1;
      start = 1'b1; data_length = len;
      for (int k = 0; k < TAPS; k++) coef_flat[32*k +: 32] = cur_coef[k];
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", busy, 1'b1);
      check("start_awvalid", {awvalid, wvalid}, 2'b11);
   endtask

   task automatic run_case(input logic [31:0] len, input bit busy_start);
      int d0;
      d0 = done_cnt;
      pulse_start(len);
      if (busy_start) begin
         repeat (5) @(posedge clk);
         #1; start = 1'b1; data_length = 32'd5;
         @(posedge clk); #1; start = 1'b0;
      end
      for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
      check("done_seen", done_cnt - d0, 1);
      check("len_reg", rsp_len, len);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy, done, err_code, err_idx, awvalid, wvalid, arvalid, rready}, 0);
      check({tag, "_addr"}, {awaddr, araddr}, 0);
      check({tag, "_wdata"}, wdata, 0);
   endtask

   initial begin
      int  d0;
      bit  found;
      axis_rst = 1'b1; start = 1'b0; data_length = '0; coef_flat = '0;
      set_dly(0, 0, 0, 0); bad_tap = -1; done_after = 3;
      rsp_len = '0; ap_started = 1'b0; poll_n = 0;
      for (int k = 0; k < TAPS; k++) rsp_taps[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      axis_rst = 1'b0;

      set_nominal(); run_case(32'd600, 1'b0);

      set_random(); run_case(32'd600, 1'b1);

      set_nominal(); bad_tap = 4; run_case(32'd600, 1'b0);

      bad_tap = -1; done_after = 0; set_random(); run_case(32'd777, 1'b0);

      set_nominal(); done_after = 3; set_dly(3, 0, 2, 2); run_case(32'd600, 1'b0);

      set_dly(0, 0, 0, 0); set_nominal();
      pulse_start(32'd600);
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(posedge clk); #1;
         if (awvalid && awaddr == 12'h018) found = 1;
      end
      check("tap6_seen", found, 1'b1);
      axis_rst = 1'b1;
      exp_q.delete(); res_q.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      check_all_zero("midrst");
      axis_rst = 1'b0;
      repeat (6) @(posedge clk);
      check("midrst_no_done", done_cnt, d0);
      run_case(32'd600, 1'b0);

      for (int n = 0; n < 4; n++) begin
         set_random();
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         bad_tap    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TAPS - 1)) : -1;
         done_after = $urandom_range(0, 10);
         run_case($urandom, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
